// File: rtl/sequential_multiplier_16b.sv
// Radix-2 shift-add 16x16 unsigned multiplier, one iteration per clock,
// built around a two-level 16-bit carry-lookahead adder.

module carry_lookahead_adder_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    gg = '0;
    gp = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end

    // Group carries are fully expanded so no group waits on its neighbour.
    gc[0] = c_in;
    gc[1] = gg[0] | (gp[0] & c_in);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c_in);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

    c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int unsigned j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end

    sum   = p ^ c;
    c_out = gc[4];
  end

endmodule

module sequential_multiplier_16b (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] m;
  logic [32:0] w;
  logic [4:0]  count;

  logic [15:0] sum;
  logic        c_out;
  logic [32:0] w_next;

  carry_lookahead_adder_16b u_adder (
    .a     (w[31:16]),
    .b     (m),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // Add-then-shift folded into one step; w[32] is always zero after a shift,
  // so the no-add branch passing it through is the same as a zero carry.
  always_comb begin
    w_next = '0;
    if (w[0]) begin
      w_next = {1'b0, c_out, sum, w[15:1]};
    end else begin
      w_next = {1'b0, w[32], w[31:16], w[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state   <= IDLE;
      m       <= '0;
      w       <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            w     <= {17'b0, b};
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          w     <= w_next;
          count <= count + 5'd1;
          if (count == 5'd15) begin
            product <= w_next[31:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sequential_multiplier_16b.md
SEQUENTIAL_MULTIPLIER_16B -- requirements
Module: sequential_multiplier_16b

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (16-bit operands, 32-bit product).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 clr  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE or DONE.
REQ-005 a  input  16  multiplicand, unsigned; sampled on the accepting edge only.
REQ-006 b  input  16  multiplier, unsigned; sampled on the accepting edge only.
REQ-007 product  output  32  registered result a*b; held until the next completion.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle pulse, high while state is DONE.

Function
REQ-010 The block SHALL implement radix-2 shift-add multiplication with one iteration per clock.
REQ-011 Each iteration's addition SHALL use one instance of carry_lookahead_adder_16b, with c_in tied 0 and c_out used.
REQ-012 Internal state: FSM {IDLE, RUN, DONE}; 16-bit multiplicand register M; 33-bit working register W = {carry, hi[15:0], lo[15:0]}; 5-bit iteration counter.
REQ-013 Acceptance edge: in IDLE or DONE with start=1, the FSM SHALL load M=a, W={1'b0, 16'h0000, b}, and counter=0, then enter RUN.
REQ-014 RUN iteration: if W[0]=1, {carry,hi} = hi + M via the adder; otherwise {carry,hi} = {0,hi}.
REQ-015 Each RUN iteration SHALL then shift W right by 1 bit and increment the counter.
REQ-016 After the 16th RUN iteration, the FSM SHALL enter DONE and load product = W[31:0] on that same edge.
REQ-017 Latency: with start accepted at edge E0, RUN iterations SHALL occur at E1..E16.
REQ-018 After E16, done SHALL be 1 and product valid; busy SHALL be 1 from after E0 through the cycle before E16.
REQ-019 DONE SHALL last exactly one cycle: at E17 the FSM goes to IDLE, or to RUN if start=1 (back-to-back accept per REQ-013).
REQ-020 start while busy SHALL be ignored; operands, counter and product are unaffected.
REQ-021 product SHALL NOT change except at the REQ-016 edge or on reset; intermediate W values are never visible.
REQ-022 Iteration count SHALL be fixed at 16 regardless of operand values (no early termination).
REQ-023 Arithmetic: the result SHALL equal the exact 32-bit unsigned product; overflow is impossible, and the carry bit is consumed by the shift.
REQ-024 busy and done SHALL never be high simultaneously.

Reset
REQ-025 On a rising edge with clr=0, the block SHALL enter IDLE with product=0, busy=0, done=0, W=0, M=0, counter=0.
REQ-026 Reset SHALL take priority over start and over any in-progress RUN; an aborted operation produces no done pulse and no product update.
REQ-027 start high on the first edge after clr returns to 1 SHALL be accepted normally.

Verification
REQ-028 a=3, b=5, start one cycle -> busy high for 16 cycles, then done pulse for 1 cycle with product=32'h0000000F; busy=0 in the done cycle.
REQ-029 a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE0001; a=16'h8000, b=16'h0002 -> product=32'h00010000 (carry path exercised).
REQ-030 a=16'h1234, b=0 -> product=0 after the full 16 iterations (no early done); then start=1 during RUN with new operands -> ignored, first result unchanged.
REQ-031 a=7, b=9, clr=0 at E8 -> busy=0, done=0, product=0 next cycle, no done pulse; a new start afterwards gives 63 on schedule.
REQ-032 Back-to-back: start held in the DONE cycle with a=100, b=200 -> first done pulse, immediate RUN, second done 17 cycles later with product=20000.
REQ-033 Random: 1000 unsigned operand pairs, each checked against the $urandom-based reference a*b at its done pulse.
